// File: rtl/xdot_ctrl.sv
// Job controller for a shared vector dot-product unit: accepts a beat count, accumulates dp_z per beat, returns the sum.
// Define XDOT_CTRL_SAT_EN to saturate the accumulator on overflow; otherwise it wraps. Overflow is flagged either way.
module xdot_ctrl #(
  parameter int unsigned INPUT_WIDTH = 16,
  parameter int unsigned VEC_WIDTH   = 4,
  parameter int unsigned ACC_WIDTH   = 48,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [LEN_WIDTH-1:0]             cmd_len,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [INPUT_WIDTH*VEC_WIDTH-1:0] x_in,
  input  logic [INPUT_WIDTH*VEC_WIDTH-1:0] y_in,
  output logic [INPUT_WIDTH*VEC_WIDTH-1:0] dp_x,
  output logic [INPUT_WIDTH*VEC_WIDTH-1:0] dp_y,
  input  logic [2*INPUT_WIDTH-1:0]         dp_z,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [ACC_WIDTH-1:0]             res_data,
  output logic                             res_ovf,
  output logic                             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [ACC_WIDTH:0]     sum;

  // One extra bit captures the carry out of the accumulator.
  assign sum = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - 2*INPUT_WIDTH){1'b0}}, dp_z};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    dp_x      = '0;
    dp_y      = '0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = cmd_len;
          state_d = (cmd_len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        in_ready = 1'b1;
        dp_x     = x_in;
        dp_y     = y_in;
        if (in_valid) begin
          cnt_d = cnt_q - 1'b1;
`ifdef XDOT_CTRL_SAT_EN
          // Once pinned at all-ones, every further nonzero beat carries again, so it stays pinned.
          if (sum[ACC_WIDTH]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[ACC_WIDTH-1:0];
          end
`else
          acc_d = sum[ACC_WIDTH-1:0];
          ovf_d = ovf_q | sum[ACC_WIDTH];
`endif
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign res_data = acc_q;
  assign res_ovf  = ovf_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: doc/xdot_ctrl.md
XDOT_CTRL -- requirements
Module: xdot_ctrl

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 16, lane operand width (unsigned).
REQ-002 SHALL have parameter VEC_WIDTH, default 4, lanes per beat.
REQ-003 SHALL have parameter ACC_WIDTH, default 48, accumulator/result width; ACC_WIDTH >= 2*INPUT_WIDTH.
REQ-004 SHALL have parameter LEN_WIDTH, default 16, beat-count width.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port cmd_valid  input  1  job request.
REQ-008 SHALL have port cmd_ready  output  1  controller can accept a job.
REQ-009 SHALL have port cmd_len  input  LEN_WIDTH  number of operand beats in job.
REQ-010 SHALL have port in_valid  input  1  operand beat present.
REQ-011 SHALL have port in_ready  output  1  controller consumes beat.
REQ-012 SHALL have port x_in  input  INPUT_WIDTH*VEC_WIDTH  packed x lanes, lane 0 in LSBs.
REQ-013 SHALL have port y_in  input  INPUT_WIDTH*VEC_WIDTH  packed y lanes, lane 0 in LSBs.
REQ-014 SHALL have port dp_x  output  INPUT_WIDTH*VEC_WIDTH  x lanes driven to shared dot-product unit.
REQ-015 SHALL have port dp_y  output  INPUT_WIDTH*VEC_WIDTH  y lanes driven to dot-product unit.
REQ-016 SHALL have port dp_z  input  2*INPUT_WIDTH  combinational dot-product result of dp_x, dp_y.
REQ-017 SHALL have port res_valid  output  1  result available.
REQ-018 SHALL have port res_ready  input  1  result consumer ready.
REQ-019 SHALL have port res_data  output  ACC_WIDTH  accumulated dot product.
REQ-020 SHALL have port res_ovf  output  1  accumulator overflowed during job.
REQ-021 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-022 SHALL implement FSM states IDLE, RUN, DONE.
REQ-023 IDLE: cmd_ready=1; on cmd_valid, acc<=0, ovf<=0, cnt<=cmd_len; next RUN if cmd_len!=0, else DONE.
REQ-024 RUN: in_ready=1, cmd_ready=0; dp_x=x_in, dp_y=y_in combinationally; other states drive dp_x=dp_y=0.
REQ-025 On in_valid&&in_ready: acc<=acc+zero-extended dp_z, cnt<=cnt-1; if cnt==1, next DONE.
REQ-026 Beats with in_valid=0 SHALL not change acc or cnt; stalls of any length are legal.
REQ-027 DONE: res_valid=1, res_data=acc, res_ovf=ovf; in_ready=0, cmd_ready=0; on res_ready, next IDLE.
REQ-028 res_valid SHALL rise the cycle after the last beat is accepted (latency 1); res_data SHALL remain stable while res_valid&&!res_ready.
REQ-029 cmd_len=0 SHALL yield res_data=0, res_ovf=0 one cycle after acceptance.
REQ-030 ovf SHALL set when an accumulation carries beyond ACC_WIDTH and stay set until next job accepted.
REQ-031 A new command SHALL not be accepted in the same cycle a result is handed off; IDLE lasts at least one cycle.
REQ-032 res_data SHALL equal acc in all states; res_ovf SHALL equal ovf in all states.

Reset
REQ-033 On rst high, state<=IDLE, acc<=0, cnt<=0, ovf<=0 immediately, regardless of clk.
REQ-034 Reset output values: cmd_ready=1, in_ready=0, res_valid=0, res_data=0, res_ovf=0, busy=0, dp_x=dp_y=0.
REQ-035 Reset mid-job SHALL discard the job; no result SHALL be produced for it.

Configuration
REQ-036 Macro XDOT_CTRL_SAT_EN defined: on overflow acc SHALL saturate to all-ones and remain there for the job; ovf set.
REQ-037 Macro XDOT_CTRL_SAT_EN undefined: acc SHALL wrap modulo 2^ACC_WIDTH; ovf set (sticky).

Verification
REQ-038 cmd_len=3, beats x=y={1,2,3,4} each (dp_z=30) -> res_data=90, res_ovf=0, res_valid one cycle after third accept.
REQ-039 cmd_len=0 -> in_ready never high, res_valid next cycle, res_data=0.
REQ-040 cmd_len=2, in_valid gaps of 5 cycles, res_ready low 4 cycles -> res_data=2*dp_z, stable while held.
REQ-041 ACC_WIDTH=32, cmd_len=2, dp_z=0xFFFF_FFFF each -> res_ovf=1; res_data=0xFFFF_FFFE wrap / 0xFFFF_FFFF with XDOT_CTRL_SAT_EN.
REQ-042 cmd_len=4, rst asserted after 2 beats -> outputs at reset values same cycle; next job cmd_len=1, dp_z=7 -> res_data=7.
